// File: rtl/aes_pkg.sv
// aes_pkg: AES-128 constants and helpers shared by the inverse key schedule.
//   SBOX          forward S-box table
//   RCON          round constants, indexed by round number (entry 0 unused)
//   AES128_ROUNDS number of AES-128 rounds
//   state_e       walk FSM states
//   sbox / sub_word / rot_word / rcon  helper functions
package aes_pkg;

   localparam int AES128_ROUNDS = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [7:0] RCON [0:AES128_ROUNDS] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   // Rounds outside 1..10 never reach the schedule; return 0 so the
   // table is never indexed out of range.
   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] v;
      v = 8'h00;
      if (r >= 4'd1 && r <= 4'(AES128_ROUNDS)) v = RCON[r];
      return v;
   endfunction

endpackage

// File: rtl/aes_inv_key_round.sv
// aes_inv_key_round: one backward step of the AES-128 key schedule.
//   key_in  [127:0]  round-r key, word 0 in [127:96]
//   round   [3:0]    r (1..10), selects Rcon
//   key_out [127:0]  round-(r-1) key
module aes_inv_key_round
   import aes_pkg::*;
(
   input  logic [127:0] key_in,
   input  logic [3:0]   round,
   output logic [127:0] key_out
);

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] p0, p1, p2, p3;

   always_comb begin
      w0 = key_in[127:96];
      w1 = key_in[95:64];
      w2 = key_in[63:32];
      w3 = key_in[31:0];
      // Undo the forward chain first; the recovered w3 feeds the S-box
      // path exactly as the forward schedule's w3 did.
      p3 = w3 ^ w2;
      p2 = w2 ^ w1;
      p1 = w1 ^ w0;
      p0 = w0 ^ sub_word(rot_word(p3)) ^ {rcon(round), 24'h0};
      key_out = {p0, p1, p2, p3};
   end

endmodule

// File: rtl/aes_inv_key_expansion.sv
// aes_inv_key_expansion: reverse AES-128 key schedule, one round per clock.
// Loads the round-10 key and presents round keys 10..0, ending with the
// cipher key.
//   clk        system clock
//   rst        synchronous reset, active low
//   start      begins a walk (accepted in IDLE/DONE when not paused)
//   last_key   round-10 key, captured with start
//   pause      freezes all state and outputs
//   round_key  current round key
//   round_idx  round number of round_key
//   key_valid  round_key/round_idx valid
//   done       pulse alongside round 0
//   ready      able to accept start
//   rd_idx     store read index
//   rd_key     stored key for rd_idx
// Build option: define AES_INV_KS_STORE_EN to keep all 11 presented keys in
// a readable register file; otherwise rd_key is tied to 0.
//
// state | meaning
// IDLE  | waiting for start, ready=1
// RUN   | presenting keys, round_idx counts down 10..0
// DONE  | walk finished, cipher key held, ready=1
module aes_inv_key_expansion
   import aes_pkg::*;
#(
   parameter int NR = AES128_ROUNDS,
   parameter int KW = 128
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [KW-1:0] last_key,
   input  logic          pause,
   output logic [KW-1:0] round_key,
   output logic [3:0]    round_idx,
   output logic          key_valid,
   output logic          done,
   output logic          ready,
   input  logic [3:0]    rd_idx,
   output logic [KW-1:0] rd_key
);

   state_e        state_q, state_d;
   logic [KW-1:0] key_q, key_d;
   logic [3:0]    idx_q, idx_d;
   logic          valid_q, valid_d;
   logic          done_q, done_d;
   logic          ready_q, ready_d;
   logic [KW-1:0] key_step;

   aes_inv_key_round u_round (
      .key_in  (key_q),
      .round   (idx_q),
      .key_out (key_step)
   );

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      done_d  = done_q;
      ready_d = ready_q;
      if (!pause) begin
         case (state_q)
            IDLE, DONE: begin
               valid_d = 1'b0;
               done_d  = 1'b0;
               ready_d = 1'b1;
               if (start) begin
                  key_d   = last_key;
                  idx_d   = 4'(NR);
                  valid_d = 1'b1;
                  ready_d = 1'b0;
                  state_d = RUN;
               end
            end
            RUN: begin
               // Terminal count: round 0 has just been presented.
               if (idx_q == 4'd0) begin
                  valid_d = 1'b0;
                  done_d  = 1'b0;
                  ready_d = 1'b1;
                  state_d = DONE;
               end else begin
                  key_d   = key_step;
                  idx_d   = idx_q - 4'd1;
                  valid_d = 1'b1;
                  done_d  = (idx_q == 4'd1);
               end
            end
            default: begin
               valid_d = 1'b0;
               done_d  = 1'b0;
               ready_d = 1'b1;
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         key_q   <= '0;
         idx_q   <= 4'd0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         ready_q <= ready_d;
      end
   end

   assign round_key = key_q;
   assign round_idx = idx_q;
   assign key_valid = valid_q;
   assign done      = done_q;
   assign ready     = ready_q;

`ifdef AES_INV_KS_STORE_EN
   logic [KW-1:0] store_q [0:NR];
   logic [KW-1:0] store_d [0:NR];

   // A presentation is consumed on its unpaused edge; capture it there.
   always_comb begin
      for (int i = 0; i <= NR; i++) store_d[i] = store_q[i];
      if (valid_q && !pause) store_d[idx_q] = key_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i <= NR; i++) store_q[i] <= '0;
      end else begin
         for (int i = 0; i <= NR; i++) store_q[i] <= store_d[i];
      end
   end

   assign rd_key = (rd_idx <= 4'(NR)) ? store_q[rd_idx] : '0;
`else
   logic unused_rd_idx;
   assign unused_rd_idx = ^rd_idx;
   assign rd_key        = '0;
`endif

endmodule

// File: tb/tb_aes_inv_key_expansion.sv
module tb_aes_inv_key_expansion;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] last_key;
   logic         pause;
   logic [127:0] round_key;
   logic [3:0]   round_idx;
   logic         key_valid;
   logic         done;
   logic         ready;
   logic [3:0]   rd_idx;
   logic [127:0] rd_key;

   int checks   = 0;
   int failures = 0;

   logic [127:0] exp_keys [0:10];
   logic [127:0] fips_last;
   logic [127:0] alt_last;
   logic [127:0] alt_cipher;

   aes_inv_key_expansion dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .last_key  (last_key),
      .pause     (pause),
      .round_key (round_key),
      .round_idx (round_idx),
      .key_valid (key_valid),
      .done      (done),
      .ready     (ready),
      .rd_idx    (rd_idx),
      .rd_key    (rd_key)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
   endtask

   task automatic start_walk(input logic [127:0] k);
      start    = 1'b1;
      last_key = k;
      step();
      start    = 1'b0;
   endtask

   task automatic wait_idx(input logic [3:0] target);
      int n;
      n = 0;
      while (!(key_valid === 1'b1 && round_idx === target) && n < 40) begin
         step();
         n++;
      end
      checks++;
      if (n >= 40) begin
         failures++;
         $display("FAIL wait_idx: round_idx=%0d never reached %0d", round_idx, target);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({key_valid, done, ready, round_idx} !== {1'b0, 1'b0, 1'b1, 4'd0}) begin
         failures++;
         $display("FAIL reset_flags: valid/done/ready/idx=%b%b%b/%0d want 001/0",
                  key_valid, done, ready, round_idx);
      end
      checks++;
      if (round_key !== 128'h0) begin
         failures++;
         $display("FAIL reset_key: got %h want 0", round_key);
      end
   endtask

   task automatic test_fips_walk();
      int valid_cnt;
      valid_cnt = 0;
      start_walk(fips_last);
      for (int i = 10; i >= 0; i--) begin
         checks++;
         if (key_valid !== 1'b1 || round_idx !== 4'(i) || round_key !== exp_keys[i]
             || done !== (i == 0) || ready !== 1'b0) begin
            failures++;
            $display("FAIL walk_r%0d: v=%b idx=%0d done=%b rdy=%b key=%h want v=1 idx=%0d done=%0d rdy=0 key=%h",
                     i, key_valid, round_idx, done, ready, round_key, i, (i == 0), exp_keys[i]);
         end
         if (key_valid === 1'b1) valid_cnt++;
         step();
      end
      for (int i = 0; i < 3; i++) begin
         if (key_valid === 1'b1) valid_cnt++;
         step();
      end
      checks++;
      if (valid_cnt != 11) begin
         failures++;
         $display("FAIL walk_valid_count: got %0d want 11", valid_cnt);
      end
      checks++;
      if (ready !== 1'b1 || done !== 1'b0 || round_idx !== 4'd0 || round_key !== exp_keys[0]) begin
         failures++;
         $display("FAIL done_hold: rdy=%b done=%b idx=%0d key=%h want 1/0/0/%h",
                  ready, done, round_idx, round_key, exp_keys[0]);
      end
   endtask

   task automatic test_pause();
      do_reset();
      start_walk(fips_last);
      wait_idx(4'd6);
      pause = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (key_valid !== 1'b1 || round_idx !== 4'd6 || round_key !== exp_keys[6]) begin
            failures++;
            $display("FAIL pause_hold%0d: v=%b idx=%0d key=%h want 1/6/%h",
                     i, key_valid, round_idx, round_key, exp_keys[6]);
         end
      end
      pause = 1'b0;
      step();
      for (int i = 5; i >= 0; i--) begin
         checks++;
         if (key_valid !== 1'b1 || round_idx !== 4'(i) || round_key !== exp_keys[i] || done !== (i == 0)) begin
            failures++;
            $display("FAIL pause_seq_r%0d: v=%b idx=%0d done=%b key=%h want idx=%0d key=%h",
                     i, key_valid, round_idx, done, round_key, i, exp_keys[i]);
         end
         step();
      end
      checks++;
      if (key_valid !== 1'b0 || ready !== 1'b1) begin
         failures++;
         $display("FAIL pause_end: v=%b rdy=%b want 0/1", key_valid, ready);
      end
   endtask

   task automatic test_reset_midwalk();
      int seen_done;
      do_reset();
      start_walk(fips_last);
      wait_idx(4'd4);
      rst = 1'b0;
      step();
      checks++;
      if (key_valid !== 1'b0 || ready !== 1'b1 || round_key !== 128'h0 || done !== 1'b0
          || round_idx !== 4'd0) begin
         failures++;
         $display("FAIL midwalk_reset: v=%b rdy=%b done=%b idx=%0d key=%h want 0/1/0/0/0",
                  key_valid, ready, done, round_idx, round_key);
      end
      rst = 1'b1;
      seen_done = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (done === 1'b1 || key_valid === 1'b1) seen_done++;
      end
      checks++;
      if (seen_done != 0) begin
         failures++;
         $display("FAIL midwalk_no_done: got %0d active cycles want 0", seen_done);
      end
   endtask

   task automatic test_start_in_run();
      do_reset();
      start_walk(fips_last);
      wait_idx(4'd7);
      start    = 1'b1;
      last_key = alt_last;
      step();
      start    = 1'b0;
      for (int i = 6; i >= 0; i--) begin
         checks++;
         if (key_valid !== 1'b1 || round_idx !== 4'(i) || round_key !== exp_keys[i]) begin
            failures++;
            $display("FAIL run_start_r%0d: v=%b idx=%0d key=%h want idx=%0d key=%h",
                     i, key_valid, round_idx, round_key, i, exp_keys[i]);
         end
         step();
      end
   endtask

   task automatic test_restart();
      // Called with the DUT sitting in DONE after a full walk.
      checks++;
      if (ready !== 1'b1) begin
         failures++;
         $display("FAIL restart_ready: got %b want 1", ready);
      end
      start_walk(alt_last);
      checks++;
      if (key_valid !== 1'b1 || round_idx !== 4'd10 || round_key !== alt_last) begin
         failures++;
         $display("FAIL restart_r10: v=%b idx=%0d key=%h want 1/10/%h", key_valid, round_idx, round_key, alt_last);
      end
      wait_idx(4'd0);
      checks++;
      if (round_key !== alt_cipher || done !== 1'b1) begin
         failures++;
         $display("FAIL restart_r0: done=%b key=%h want 1/%h", done, round_key, alt_cipher);
      end
   endtask

   task automatic test_store();
      do_reset();
      start_walk(fips_last);
      wait_idx(4'd0);
      step();
`ifdef AES_INV_KS_STORE_EN
      rd_idx = 4'd9;
      #1;
      checks++;
      if (rd_key !== exp_keys[9]) begin
         failures++;
         $display("FAIL store_r9: got %h want %h", rd_key, exp_keys[9]);
      end
      rd_idx = 4'd0;
      #1;
      checks++;
      if (rd_key !== exp_keys[0]) begin
         failures++;
         $display("FAIL store_r0: got %h want %h", rd_key, exp_keys[0]);
      end
      rd_idx = 4'd12;
      #1;
      checks++;
      if (rd_key !== 128'h0) begin
         failures++;
         $display("FAIL store_oob: got %h want 0", rd_key);
      end
`else
      rd_idx = 4'd9;
      #1;
      checks++;
      if (rd_key !== 128'h0) begin
         failures++;
         $display("FAIL store_off: got %h want 0", rd_key);
      end
`endif
   endtask

   initial begin
      exp_keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      exp_keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      exp_keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      exp_keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      exp_keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      exp_keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      exp_keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      exp_keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      exp_keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      exp_keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
      exp_keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
      fips_last    = exp_keys[10];
      alt_last     = 128'h13111d7fe3944a17f307a78b4d2b30c5;
      alt_cipher   = 128'h000102030405060708090a0b0c0d0e0f;

      rst      = 1'b0;
      start    = 1'b0;
      last_key = '0;
      pause    = 1'b0;
      rd_idx   = 4'd0;

      test_reset();
      test_fips_walk();
      test_restart();
      test_pause();
      test_reset_midwalk();
      test_start_in_run();
      test_store();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/aes_inv_key_expansion.md
Name: aes_inv_key_expansion

Overview:
Reverse AES-128 key schedule for the decryption datapath. Loads the final (round-10) round key and walks the schedule backwards one round per clock. Emits round keys 10 down to 0 in the order the inverse cipher consumes them, ending with the recovered cipher key. Sits beside AES_key_expansion and feeds the inverse-round pipeline without storing all 11 forward keys.

Parameters:
NR, 10, number of AES-128 rounds; fixed for this block; sizes round_idx and the Rcon table.
KW, 128, round key width in bits.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-low.
start  input  1  level; sampled only in IDLE and DONE; begins a reverse walk.
last_key  input  128  round-10 key; captured on the start cycle.
pause  input  1  freezes all state and outputs while high (reset still acts).
round_key  output  128  current round key, FIPS-197 byte order (byte 0 = [127:120]).
round_idx  output  4  round number of round_key (10..0).
key_valid  output  1  round_key/round_idx valid this cycle.
done  output  1  one-cycle pulse with round 0 (cipher key).
ready  output  1  high when idle and able to accept start.
rd_idx  input  4  store read index (STORE feature).
rd_key  output  128  stored key for rd_idx (STORE feature).

Behaviour:
- Reset (rst=0 at clk edge): state=IDLE, round_key=0, round_idx=0, key_valid=0, done=0, ready=1, round counter=0. Reset mid-walk aborts immediately; no partial done.
- FSM states: IDLE, RUN, DONE.
- IDLE: ready=1, key_valid=0. On start=1 and pause=0: capture last_key into the key register, set round_idx=10, go to RUN, ready=0. Latency start→first key is 1 cycle.
- RUN: key_valid=1 every unpaused cycle. Each unpaused cycle, the register loads the inverse step of the current key and round_idx decrements.
- Inverse step for key r (words w0..w3, r≥1):
  - w3' = w3^w2; w2' = w2^w1; w1' = w1^w0.
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ {Rcon[r],24'h0}.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- When round_idx=0 is presented: done=1 for that cycle, then go to DONE.
- Total walk: 11 consecutive key_valid cycles (rounds 10..0) when never paused.
- DONE: key_valid=0. round_key holds the cipher key and round_idx=0 until the next start. ready=1. start=1 restarts exactly as from IDLE.
- start while in RUN: ignored; the walk is not restarted.
- pause=1: no state, counter or output change. A key_valid that was high stays high but counts as one presentation only; downstream samples it on the unpaused edge. done is also held, and counts once.
- pause and start together in IDLE: start is ignored.
- round_idx never wraps below 0; the Rcon index is only used for r in 1..10.

Optional Feature:
AES_INV_KS_STORE_EN.
- Defined: an 11×128 register file captures each round_key at its valid unpaused cycle, indexed by round_idx. rd_key = store[rd_idx] combinationally; rd_idx>10 returns 0. The store is cleared on reset, and entries persist across DONE.
- Undefined: no storage is built, rd_key is tied to 0, and rd_idx is unused.

Decomposition:
- Package aes_pkg holds:
  - the SBOX function/table and RotWord/SubWord functions;
  - RCON constant array;
  - AES128_ROUNDS=10;
  - FSM state typedef {IDLE,RUN,DONE}.
- One combinational sub-module: aes_inv_key_round (inputs key_in[127:0] and round[3:0], output key_out[127:0]). It uses four S-box lookups on w3'.
- The top holds the FSM, counter, key register and optional store.

Test Plan:
- FIPS-197 walk: rst low 2 cycles, start=1 with last_key=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Next cycle: round_idx=10 and that key.
  - Next: idx 9 = ac7766f319fadc2128d12941575c006e.
  - Idx 1 = a0fafe1788542cb123a339392a6c7605.
  - Idx 0 = 2b7e151628aed2a6abf7158809cf4f3c with done=1.
  - Exactly 11 key_valid cycles.
- Pause: raise pause for 3 cycles while round_idx=6 → round_key/round_idx unchanged throughout; after release, idx 5 follows; total sequence identical to the unpaused walk.
- Reset mid-walk: rst=0 at round_idx=4 → next cycle key_valid=0, ready=1, round_key=0; no done pulse.
- Start in RUN: pulse start at idx 7 with a different last_key → walk continues unchanged to idx 0; new key is not captured.
- Restart from DONE: after done, start with last_key=13111d7fe3944a17f307a78b4d2b30c5 (FIPS-197 AES-128 cipher example) → idx 0 yields 000102030405060708090a0b0c0d0e0f.
- With AES_INV_KS_STORE_EN: after the FIPS walk, rd_idx=9 → ac7766f3...575c006e; rd_idx=0 → 2b7e1516...09cf4f3c; rd_idx=12 → 0.
